issue_scheduler: RTL and testbench

- Issue controller for the 4-slot instruction queue output window.
- Each cycle it selects up to 4 ready slots (oldest first) for dispatch to:
  - 2 single-cycle ALUs
  - 1 unpipelined multiplier
  - 1 memory port with valid/ready handshake
- Drives the queue's per-slot removal strobes and registered dispatch buses.
- Handles branch flush squash.

---
 rtl/issue_scheduler.sv | 187 ++++++++++++++++++
 tb/tb_issue_scheduler.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/issue_scheduler.sv
// Issue controller for the 4-slot queue window: oldest-first grants to 2 ALUs, MUL, MEM.
// Define ISSUE_STATS_EN to add the stat_issued/stat_stall counters.
module issue_scheduler #(
    parameter int des       = 4,
    parameter int source1   = 4,
    parameter int source2   = 4,
    parameter int immediate = 5,
    parameter int branch_id = 3,
    parameter int MUL_LAT   = 3
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic [3:0]                                slot_vld,
    input  logic [3:0]                                slot_rdy,
    input  logic [15:0]                               slot_op,
    input  logic [4*des-1:0]                          slot_des,
    input  logic [4*source1-1:0]                      slot_s1,
    input  logic [4*source2-1:0]                      slot_s2,
    input  logic [4*immediate-1:0]                    slot_ime,
    input  logic [4*branch_id-1:0]                    slot_branch,
    input  logic                                      flush_en,
    input  logic [branch_id-1:0]                      flush_id,
    output logic [3:0]                                ins_in,
    output logic                                      alu0_vld,
    output logic                                      alu1_vld,
    output logic [des+source1+source2+4+immediate-1:0] alu0_bus,
    output logic [des+source1+source2+4+immediate-1:0] alu1_bus,
    output logic                                      mul_vld,
    output logic [des+source1+source2+4+immediate-1:0] mul_bus,
    output logic                                      mul_busy,
    output logic                                      mem_vld,
    output logic [des+source1+source2+4+immediate-1:0] mem_bus,
    input  logic                                      mem_ready,
    output logic [3*branch_id-1:0]                    branch_out
`ifdef ISSUE_STATS_EN
    ,
    output logic [15:0]                               stat_issued,
    output logic [15:0]                               stat_stall
`endif
);
    localparam int BW = des + source1 + source2 + 4 + immediate;

    typedef enum logic {M_IDLE, M_BUSY} mul_st_t;
    typedef enum logic {Q_IDLE, Q_REQ} mem_st_t;

    mul_st_t              mul_state;
    mem_st_t              mem_state;
    logic [2:0]           mul_cnt;
    logic [branch_id-1:0] alu0_tag, mul_tag, mem_tag;

    logic [BW-1:0]        bus [4];
    logic [branch_id-1:0] tag [4];
    logic [3:0]           cand, grant;
    logic [1:0]           a_cnt, a_sel0, a_sel1, m_sel, q_sel;
    logic                 m_g, q_g, mul_free, mem_free;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            bus[i] = {slot_des[i*des +: des], slot_s1[i*source1 +: source1],
                      slot_s2[i*source2 +: source2], slot_op[i*4 +: 4],
                      slot_ime[i*immediate +: immediate]};
            tag[i] = slot_branch[i*branch_id +: branch_id];
        end
    end

    assign cand     = slot_vld & slot_rdy & {4{~flush_en}};
    assign mul_free = (mul_state == M_IDLE);
    assign mem_free = (mem_state == Q_IDLE) || mem_ready;

    // Oldest-first scan; a blocked slot never stalls younger ones.
    always_comb begin
        grant  = '0;
        a_cnt  = '0;
        a_sel0 = '0;
        a_sel1 = '0;
        m_sel  = '0;
        q_sel  = '0;
        m_g    = 1'b0;
        q_g    = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (cand[i]) begin
                case (slot_op[i*4+2 +: 2])
                    2'b10: begin
                        if (mul_free && !m_g) begin
                            grant[i] = 1'b1;
                            m_g      = 1'b1;
                            m_sel    = i[1:0];
                        end
                    end
                    2'b11: begin
                        if (mem_free && !q_g) begin
                            grant[i] = 1'b1;
                            q_g      = 1'b1;
                            q_sel    = i[1:0];
                        end
                    end
                    default: begin
                        if (a_cnt < 2'd2) begin
                            grant[i] = 1'b1;
                            if (a_cnt == 2'd0) a_sel0 = i[1:0];
                            else               a_sel1 = i[1:0];
                            a_cnt = a_cnt + 2'd1;
                        end
                    end
                endcase
            end
        end
    end

    assign ins_in     = grant;
    assign mul_busy   = (mul_state == M_BUSY);
    assign branch_out = {alu0_tag, mul_tag, mem_tag};

    always_ff @(posedge clk) begin
        if (rst) begin
            alu0_vld  <= 1'b0;
            alu1_vld  <= 1'b0;
            alu0_bus  <= '0;
            alu1_bus  <= '0;
            alu0_tag  <= '0;
            mul_vld   <= 1'b0;
            mul_bus   <= '0;
            mul_tag   <= '0;
            mul_cnt   <= '0;
            mul_state <= M_IDLE;
            mem_vld   <= 1'b0;
            mem_bus   <= '0;
            mem_tag   <= '0;
            mem_state <= Q_IDLE;
        end else begin
            alu0_vld <= (a_cnt != 2'd0);
            alu1_vld <= (a_cnt == 2'd2);
            if (a_cnt != 2'd0) begin
                alu0_bus <= bus[a_sel0];
                alu0_tag <= tag[a_sel0];
            end
            if (a_cnt == 2'd2) alu1_bus <= bus[a_sel1];

            mul_vld <= m_g;
            if (m_g) begin
                mul_bus <= bus[m_sel];
                mul_tag <= tag[m_sel];
                // A 1-cycle multiplier never enters BUSY so muls can go back-to-back.
                if (MUL_LAT > 1) begin
                    mul_state <= M_BUSY;
                    mul_cnt   <= 3'(MUL_LAT - 1);
                end
            end else if (mul_state == M_BUSY) begin
                if ((flush_en && mul_tag == flush_id) || mul_cnt == 3'd0)
                    mul_state <= M_IDLE;
                else
                    mul_cnt <= mul_cnt - 3'd1;
            end

            if (q_g) begin
                mem_state <= Q_REQ;
                mem_vld   <= 1'b1;
                mem_bus   <= bus[q_sel];
                mem_tag   <= tag[q_sel];
            end else if (mem_state == Q_REQ &&
                         (mem_ready || (flush_en && mem_tag == flush_id))) begin
                mem_state <= Q_IDLE;
                mem_vld   <= 1'b0;
            end
        end
    end

`ifdef ISSUE_STATS_EN
    logic [2:0]  pop;
    logic [16:0] isum;

    assign pop  = 3'(grant[0]) + 3'(grant[1]) + 3'(grant[2]) + 3'(grant[3]);
    assign isum = {1'b0, stat_issued} + 17'(pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_issued <= '0;
            stat_stall  <= '0;
        end else begin
            stat_issued <= isum[16] ? 16'hFFFF : isum[15:0];
            if (|cand && grant == 4'b0 && stat_stall != 16'hFFFF)
                stat_stall <= stat_stall + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_issue_scheduler.sv
// Directed self-checking bench for issue_scheduler (default MUL_LAT=3).
module tb_issue_scheduler;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  slot_vld, slot_rdy;
    logic [15:0] slot_op;
    logic [15:0] slot_des, slot_s1, slot_s2;
    logic [19:0] slot_ime;
    logic [11:0] slot_branch;
    logic        flush_en;
    logic [2:0]  flush_id;
    logic [3:0]  ins_in;
    logic        alu0_vld, alu1_vld, mul_vld, mul_busy, mem_vld, mem_ready;
    logic [20:0] alu0_bus, alu1_bus, mul_bus, mem_bus;
    logic [8:0]  branch_out;
`ifdef ISSUE_STATS_EN
    logic [15:0] stat_issued, stat_stall;
`endif

    int vectors = 0;
    int miscompares = 0;

    issue_scheduler dut (
        .clk(clk), .rst(rst),
        .slot_vld(slot_vld), .slot_rdy(slot_rdy), .slot_op(slot_op),
        .slot_des(slot_des), .slot_s1(slot_s1), .slot_s2(slot_s2),
        .slot_ime(slot_ime), .slot_branch(slot_branch),
        .flush_en(flush_en), .flush_id(flush_id),
        .ins_in(ins_in),
        .alu0_vld(alu0_vld), .alu1_vld(alu1_vld),
        .alu0_bus(alu0_bus), .alu1_bus(alu1_bus),
        .mul_vld(mul_vld), .mul_bus(mul_bus), .mul_busy(mul_busy),
        .mem_vld(mem_vld), .mem_bus(mem_bus), .mem_ready(mem_ready),
        .branch_out(branch_out)
`ifdef ISSUE_STATS_EN
        , .stat_issued(stat_issued), .stat_stall(stat_stall)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Slot n carries des=n, s1=n+4, s2=n+8, ime=n+16, tag=n.
    function automatic logic [20:0] eb(input int n, input logic [3:0] op);
        return {4'(n), 4'(n + 4), 4'(n + 8), op, 5'(n + 16)};
    endfunction

    initial begin
        for (int n = 1; n <= 4; n++) begin
            slot_des[4*(n-1) +: 4]    = 4'(n);
            slot_s1[4*(n-1) +: 4]     = 4'(n + 4);
            slot_s2[4*(n-1) +: 4]     = 4'(n + 8);
            slot_ime[5*(n-1) +: 5]    = 5'(n + 16);
            slot_branch[3*(n-1) +: 3] = 3'(n);
        end
        rst = 1'b1; slot_vld = 4'h0; slot_rdy = 4'h0; slot_op = 16'h0;
        flush_en = 1'b0; flush_id = 3'd0; mem_ready = 1'b0;
        tick(); tick();
        chk("rst_alu0_vld", 64'(alu0_vld), 0);
        chk("rst_mul_busy", 64'(mul_busy), 0);
        chk("rst_mem_vld", 64'(mem_vld), 0);
        chk("rst_branch", 64'(branch_out), 0);
        chk("rst_bus", 64'(alu0_bus), 0);
        rst = 1'b0;
        tick();

        // Four ALU ops: only two granted
        slot_vld = 4'hF; slot_rdy = 4'hF; slot_op = 16'h5410;
        #1 chk("alu4_ins", 64'(ins_in), 64'b0011);
        tick();
        chk("alu4_v0", 64'(alu0_vld), 1);
        chk("alu4_b0", 64'(alu0_bus), 64'(eb(1, 4'h0)));
        chk("alu4_v1", 64'(alu1_vld), 1);
        chk("alu4_b1", 64'(alu1_bus), 64'(eb(2, 4'h1)));
        chk("alu4_tag", 64'(branch_out[8:6]), 1);
        chk("alu4_mulv", 64'(mul_vld), 0);
        slot_vld = 4'h0;
        #1 chk("empty_ins", 64'(ins_in), 0);
        tick();
        chk("empty_v0", 64'(alu0_vld), 0);
        chk("hold_b0", 64'(alu0_bus), 64'(eb(1, 4'h0)));

        // Out-of-order around an unready slot 1
        slot_vld = 4'hF; slot_rdy = 4'b1110;
        #1 chk("ooo_ins", 64'(ins_in), 64'b0110);
        tick();
        chk("ooo_b0", 64'(alu0_bus), 64'(eb(2, 4'h1)));
        chk("ooo_b1", 64'(alu1_bus), 64'(eb(3, 4'h4)));
        slot_vld = 4'h0; slot_rdy = 4'hF;
        tick();

        // MUL, MUL, ALU, MEM
        slot_vld = 4'hF; slot_op = 16'hC098; mem_ready = 1'b1;
        #1 chk("mix_ins", 64'(ins_in), 64'b1101);
        tick();
        chk("mix_mulv", 64'(mul_vld), 1);
        chk("mix_mulb", 64'(mul_bus), 64'(eb(1, 4'h8)));
        chk("mix_busy1", 64'(mul_busy), 1);
        chk("mix_alub", 64'(alu0_bus), 64'(eb(3, 4'h0)));
        chk("mix_alu1v", 64'(alu1_vld), 0);
        chk("mix_memv", 64'(mem_vld), 1);
        chk("mix_memb", 64'(mem_bus), 64'(eb(4, 4'hC)));
        slot_vld = 4'b0010;
        #1 chk("mul_wait1", 64'(ins_in), 0);
        tick();
        chk("mix_mulv2", 64'(mul_vld), 0);
        chk("mix_busy2", 64'(mul_busy), 1);
        chk("mix_memv2", 64'(mem_vld), 0);
        tick();
        chk("mix_busy3", 64'(mul_busy), 1);
        chk("mul_wait3", 64'(ins_in), 0);
        tick();
        chk("mix_busy4", 64'(mul_busy), 0);
        chk("mul2_ins", 64'(ins_in), 64'b0010);
        tick();
        chk("mul2_v", 64'(mul_vld), 1);
        chk("mul2_b", 64'(mul_bus), 64'(eb(2, 4'h9)));
        chk("mul2_tag", 64'(branch_out[5:3]), 2);
        slot_vld = 4'h0;
        tick(); tick(); tick();
        chk("mul2_idle", 64'(mul_busy), 0);

        // MEM held for 5 cycles, second MEM loads on accept
        mem_ready = 1'b0; slot_op = 16'h00DC; slot_vld = 4'b0001;
        #1 chk("mem1_ins", 64'(ins_in), 64'b0001);
        tick();
        slot_vld = 4'b0010;
        for (int k = 0; k < 5; k++) begin
            chk("mem_hold_v", 64'(mem_vld), 1);
            chk("mem_hold_b", 64'(mem_bus), 64'(eb(1, 4'hC)));
            chk("mem_hold_ins", 64'(ins_in), 0);
            tick();
        end
        mem_ready = 1'b1;
        #1 chk("mem2_ins", 64'(ins_in), 64'b0010);
        tick();
        chk("mem2_v", 64'(mem_vld), 1);
        chk("mem2_b", 64'(mem_bus), 64'(eb(2, 4'hD)));
        chk("mem2_tag", 64'(branch_out[2:0]), 2);
        slot_vld = 4'h0;
        tick();
        chk("mem2_done", 64'(mem_vld), 0);

        // Flush: non-matching tag holds MEM, matching tag drops it
        mem_ready = 1'b0; slot_op = 16'h0E00; slot_vld = 4'b0100;
        #1 chk("fl_ins", 64'(ins_in), 64'b0100);
        tick();
        slot_op = 16'h0E00; slot_vld = 4'b0001;
        flush_en = 1'b1; flush_id = 3'd2;
        #1 chk("fl2_ins", 64'(ins_in), 0);
        tick();
        chk("fl2_memv", 64'(mem_vld), 1);
        chk("fl2_alu", 64'(alu0_vld), 0);
        flush_id = 3'd3;
        #1 chk("fl3_ins", 64'(ins_in), 0);
        tick();
        chk("fl3_memv", 64'(mem_vld), 0);

        // Flush a busy multiplier with matching tag
        flush_en = 1'b0; slot_op = 16'h0008; slot_vld = 4'b0001;
        tick();
        slot_vld = 4'h0;
        chk("flm_busy", 64'(mul_busy), 1);
        flush_en = 1'b1; flush_id = 3'd1;
        tick();
        flush_en = 1'b0;
        chk("flm_idle", 64'(mul_busy), 0);

        // Reset mid MUL busy and MEM request
        slot_op = 16'hC008; slot_vld = 4'b1001; mem_ready = 1'b0;
        #1 chk("rs_ins", 64'(ins_in), 64'b1001);
        tick();
        slot_vld = 4'h0;
        chk("rs_busy", 64'(mul_busy), 1);
        chk("rs_memv", 64'(mem_vld), 1);
        rst = 1'b1;
        tick();
        chk("rs2_busy", 64'(mul_busy), 0);
        chk("rs2_memv", 64'(mem_vld), 0);
        chk("rs2_mulv", 64'(mul_vld), 0);
        chk("rs2_memb", 64'(mem_bus), 0);
        chk("rs2_branch", 64'(branch_out), 0);
`ifdef ISSUE_STATS_EN
        chk("rs2_stat_i", 64'(stat_issued), 0);
        chk("rs2_stat_s", 64'(stat_stall), 0);
`endif
        rst = 1'b0;
        tick();
        chk("rs3_memv", 64'(mem_vld), 0);
        chk("rs3_busy", 64'(mul_busy), 0);
`ifdef ISSUE_STATS_EN
        slot_op = 16'h000C; slot_vld = 4'b0001;
        tick();
        tick();
        chk("st_issued", 64'(stat_issued), 1);
        chk("st_stall", 64'(stat_stall), 1);
        slot_vld = 4'h0;
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
